// File: rtl/spike_encoder_if.sv
// spike_encoder_if: intensity-vector input and per-step spike output handshakes for the TTFS encoder
`ifndef NUM_SPIKES
`define NUM_SPIKES 16
`endif
interface spike_encoder_if #(
    parameter int NUM_INPUTS = `NUM_SPIKES,
    parameter int IBITS      = 8,
    parameter int TBITS      = 3
);
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_INPUTS*IBITS-1:0] in_data;
    logic [NUM_INPUTS-1:0]       spikes_out;
    logic                        spikes_valid;
    logic                        spikes_ready;
    logic [TBITS-1:0]            step_idx;
    logic                        window_last;
    modport master (
        input  in_valid, in_data, spikes_ready,
        output in_ready, spikes_out, spikes_valid, step_idx, window_last
    );
    modport slave (
        output in_valid, in_data, spikes_ready,
        input  in_ready, spikes_out, spikes_valid, step_idx, window_last
    );
endinterface

// File: rtl/spike_encoder.sv
// spike_encoder: time-to-first-spike encoder replaying one intensity vector over a 2^TBITS-step window
`ifndef NUM_SPIKES
`define NUM_SPIKES 16
`endif
module spike_encoder #(
    parameter int NUM_INPUTS    = `NUM_SPIKES,
    parameter int IBITS         = 8,
    parameter int TBITS         = 3,
    parameter int MIN_INTENSITY = 1
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               flush,
    output logic               busy,
    spike_encoder_if.master    bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [IBITS-1:0] MAXV  = '1;
    localparam logic [IBITS-1:0] MIN_V = IBITS'(MIN_INTENSITY);
    localparam logic [TBITS-1:0] LAST  = '1;
    state_t                                state_q, state_d;
    logic [TBITS-1:0]                      step_q, step_d;
    logic [NUM_INPUTS-1:0][TBITS-1:0]      t_q, t_d, t_in;
    logic [NUM_INPUTS-1:0]                 en_q, en_d, en_in;
    logic                                  run;
    assign run = state_q == RUN;
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        // brighter lanes map to earlier steps: invert, then keep the top TBITS bits
        assign t_in[i]           = TBITS'((MAXV - bus.in_data[i*IBITS +: IBITS]) >> (IBITS - TBITS));
        assign en_in[i]          = bus.in_data[i*IBITS +: IBITS] >= MIN_V;
        assign bus.spikes_out[i] = run && en_q[i] && t_q[i] == step_q;
    end
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        t_d     = t_q;
        en_d    = en_q;
        if (state_q == IDLE) begin
            if (bus.in_valid) begin
                state_d = RUN;
                step_d  = '0;
                t_d     = t_in;
                en_d    = en_in;
            end
        end else if (flush) begin
            state_d = IDLE;
            step_d  = '0;
        end else if (bus.spikes_ready) begin
            state_d = step_q == LAST ? IDLE : RUN;
            step_d  = step_q + TBITS'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            step_q  <= '0;
            t_q     <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            t_q     <= t_d;
            en_q    <= en_d;
        end
    end
    assign busy             = run;
    assign bus.in_ready     = state_q == IDLE;
    assign bus.spikes_valid = run;
    assign bus.step_idx     = step_q;
    assign bus.window_last  = run && step_q == LAST;
endmodule

// File: tb/tb_spike_encoder.sv
// tb_spike_encoder: directed tests of the TTFS spike encoder with hand-computed spike schedules
module tb_spike_encoder;
    logic clk = 0;
    logic rst_l = 0;
    logic flush = 0;
    logic busy;
    int   n_tests = 0;
    int   n_fail  = 0;
    spike_encoder_if #(.NUM_INPUTS(16), .IBITS(8), .TBITS(3)) bus ();
    spike_encoder #(.NUM_INPUTS(16), .IBITS(8), .TBITS(3), .MIN_INTENSITY(1)) dut (
        .clk(clk), .rst_l(rst_l), .flush(flush), .busy(busy), .bus(bus)
    );
    always #5 clk = ~clk;
    // lane0=255 -> t0, lane1=128 -> t3, lane2=0 disabled, lanes3..15=64 -> t5
    logic [15:0] exp_a [8] = '{16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'hFFF8, 16'h0000, 16'h0000};
    // lanes 31,32,0,1 then zeros: t7, t6, never, t7
    logic [15:0] exp_b [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0009};
    function automatic logic [127:0] mk(input logic [7:0] a, b, c, d, rest);
        logic [127:0] v;
        for (int i = 0; i < 16; i++)
            v[i*8 +: 8] = i == 0 ? a : i == 1 ? b : i == 2 ? c : i == 3 ? d : rest;
        return v;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [127:0] v);
        bus.in_valid = 1;
        bus.in_data  = v;
        tick();
        bus.in_valid = 0;
    endtask
    task automatic test_reset();
        #2;
        n_tests++; if (bus.spikes_valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", bus.spikes_valid); n_fail++; end
        n_tests++; if (bus.spikes_out !== 16'h0) begin $display("FAIL reset_spikes got %h exp 0000", bus.spikes_out); n_fail++; end
        n_tests++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", busy); n_fail++; end
        @(negedge clk);
        rst_l = 1;
        tick();
        n_tests++; if (bus.in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); n_fail++; end
        n_tests++; if (bus.step_idx !== 3'd0) begin $display("FAIL reset_step got %0d exp 0", bus.step_idx); n_fail++; end
    endtask
    task automatic test_basic();
        bus.spikes_ready = 1;
        start(mk(8'd255, 8'd128, 8'd0, 8'd64, 8'd64));
        for (int s = 0; s < 8; s++) begin
            n_tests++; if (bus.spikes_valid !== 1'b1 || busy !== 1'b1) begin $display("FAIL basic_valid step %0d got %b/%b exp 1/1", s, bus.spikes_valid, busy); n_fail++; end
            n_tests++; if (bus.step_idx !== 3'(s)) begin $display("FAIL basic_step got %0d exp %0d", bus.step_idx, s); n_fail++; end
            n_tests++; if (bus.spikes_out !== exp_a[s]) begin $display("FAIL basic_spikes step %0d got %h exp %h", s, bus.spikes_out, exp_a[s]); n_fail++; end
            n_tests++; if (bus.window_last !== (s == 7)) begin $display("FAIL basic_last step %0d got %b exp %b", s, bus.window_last, s == 7); n_fail++; end
            n_tests++; if (bus.in_ready !== 1'b0) begin $display("FAIL basic_in_ready_run step %0d got %b exp 0", s, bus.in_ready); n_fail++; end
            tick();
        end
        n_tests++; if (bus.in_ready !== 1'b1 || bus.spikes_valid !== 1'b0) begin $display("FAIL basic_end got ready=%b valid=%b exp 1/0", bus.in_ready, bus.spikes_valid); n_fail++; end
        n_tests++; if (bus.spikes_out !== 16'h0) begin $display("FAIL basic_idle_spikes got %h exp 0000", bus.spikes_out); n_fail++; end
    endtask
    task automatic test_stall();
        int cnt = 0;
        int seen3 = 0;
        bus.spikes_ready = 1;
        start(mk(8'd255, 8'd128, 8'd0, 8'd64, 8'd64));
        while (bus.spikes_valid && cnt < 40) begin
            if (bus.step_idx == 3'd3) begin
                n_tests++; if (bus.spikes_out !== 16'h0002) begin $display("FAIL stall_hold got %h exp 0002", bus.spikes_out); n_fail++; end
                bus.spikes_ready = seen3 >= 5;
                seen3++;
            end else bus.spikes_ready = 1;
            tick();
            cnt++;
        end
        bus.spikes_ready = 1;
        n_tests++; if (cnt != 13) begin $display("FAIL stall_window_len got %0d exp 13", cnt); n_fail++; end
        n_tests++; if (seen3 != 6) begin $display("FAIL stall_step3_cycles got %0d exp 6", seen3); n_fail++; end
    endtask
    task automatic test_back_to_back();
        int fires [16];
        for (int i = 0; i < 16; i++) fires[i] = 0;
        bus.spikes_ready = 1;
        start(mk(8'd255, 8'd128, 8'd0, 8'd64, 8'd64));
        bus.in_valid = 1;
        bus.in_data  = mk(8'd200, 8'd200, 8'd200, 8'd200, 8'd200);
        for (int c = 0; c < 17; c++) begin
            if (c == 8) begin
                n_tests++; if (bus.in_ready !== 1'b1 || bus.spikes_valid !== 1'b0) begin $display("FAIL b2b_bubble got ready=%b valid=%b exp 1/0", bus.in_ready, bus.spikes_valid); n_fail++; end
            end
            if (c == 9) begin
                n_tests++; if (bus.spikes_valid !== 1'b1 || bus.step_idx !== 3'd0) begin $display("FAIL b2b_second_start got valid=%b step=%0d exp 1/0", bus.spikes_valid, bus.step_idx); n_fail++; end
                bus.in_valid = 0;
            end
            if (c == 10) begin
                n_tests++; if (bus.spikes_out !== 16'hFFFF) begin $display("FAIL b2b_second_step1 got %h exp ffff", bus.spikes_out); n_fail++; end
            end
            for (int i = 0; i < 16; i++) if (bus.spikes_valid && bus.spikes_out[i]) fires[i]++;
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (fires[i] != (i == 2 ? 1 : 2)) begin $display("FAIL b2b_fires lane %0d got %0d exp %0d", i, fires[i], i == 2 ? 1 : 2); n_fail++; end
        end
        n_tests++; if (bus.in_ready !== 1'b1) begin $display("FAIL b2b_end_ready got %b exp 1", bus.in_ready); n_fail++; end
    endtask
    task automatic test_flush();
        logic [15:0] seen = '0;
        bus.spikes_ready = 1;
        start(mk(8'd255, 8'd128, 8'd0, 8'd64, 8'd64));
        for (int s = 0; s < 2; s++) begin
            seen |= bus.spikes_out;
            tick();
        end
        n_tests++; if (bus.step_idx !== 3'd2) begin $display("FAIL flush_pre_step got %0d exp 2", bus.step_idx); n_fail++; end
        flush = 1;
        tick();
        flush = 0;
        n_tests++; if (bus.spikes_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin $display("FAIL flush_idle got valid=%b ready=%b busy=%b exp 0/1/0", bus.spikes_valid, bus.in_ready, busy); n_fail++; end
        n_tests++; if (bus.step_idx !== 3'd0) begin $display("FAIL flush_step got %0d exp 0", bus.step_idx); n_fail++; end
        for (int c = 0; c < 8; c++) begin
            seen |= bus.spikes_out;
            tick();
        end
        n_tests++; if (seen !== 16'h0001) begin $display("FAIL flush_fired got %h exp 0001", seen); n_fail++; end
        flush = 1;
        start(mk(8'd255, 8'd128, 8'd0, 8'd64, 8'd64));
        flush = 0;
        n_tests++; if (busy !== 1'b1 || bus.spikes_out !== 16'h0001) begin $display("FAIL flush_idle_accept got busy=%b spikes=%h exp 1/0001", busy, bus.spikes_out); n_fail++; end
        for (int c = 0; c < 8; c++) tick();
    endtask
    task automatic test_reset_mid();
        bus.spikes_ready = 1;
        start(mk(8'd255, 8'd128, 8'd0, 8'd64, 8'd64));
        for (int s = 0; s < 5; s++) tick();
        n_tests++; if (bus.spikes_out !== 16'hFFF8) begin $display("FAIL rstmid_pre got %h exp fff8", bus.spikes_out); n_fail++; end
        #2 rst_l = 0;
        #1;
        n_tests++; if (bus.spikes_valid !== 1'b0 || bus.spikes_out !== 16'h0) begin $display("FAIL rstmid_async got valid=%b spikes=%h exp 0/0000", bus.spikes_valid, bus.spikes_out); n_fail++; end
        n_tests++; if (bus.window_last !== 1'b0 || busy !== 1'b0) begin $display("FAIL rstmid_flags got last=%b busy=%b exp 0/0", bus.window_last, busy); n_fail++; end
        @(negedge clk);
        rst_l = 1;
        tick();
        n_tests++; if (bus.in_ready !== 1'b1 || bus.step_idx !== 3'd0) begin $display("FAIL rstmid_release got ready=%b step=%0d exp 1/0", bus.in_ready, bus.step_idx); n_fail++; end
    endtask
    task automatic test_boundary();
        bus.spikes_ready = 1;
        start(mk(8'd31, 8'd32, 8'd0, 8'd1, 8'd0));
        for (int s = 0; s < 8; s++) begin
            n_tests++; if (bus.spikes_out !== exp_b[s]) begin $display("FAIL boundary step %0d got %h exp %h", s, bus.spikes_out, exp_b[s]); n_fail++; end
            tick();
        end
        n_tests++; if (bus.in_ready !== 1'b1) begin $display("FAIL boundary_end got %b exp 1", bus.in_ready); n_fail++; end
    endtask
    initial begin
        bus.in_valid     = 0;
        bus.in_data      = '0;
        bus.spikes_ready = 1;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
